// File: rtl/loop_apu_sequencer.sv
// -----------------------------------------------------------------------------
// loop_apu_sequencer
//   Loop-stack and address-pointer-unit engine for the control unit. START and
//   END loop instructions are retired here instead of being issued to the
//   instruction queue. The block tracks nested loop counters, unrolls
//   independent loops in batches of up to SUPERSCALAR_WIDTH iterations,
//   advances or rewinds the APU address registers by each loop's stride, and
//   reports the PC jump for the instruction it retired.
//
//   Ports
//     clk, reset          clock; asynchronous active-low reset
//     cfg_we/idx/base/coef  APU configuration write (IDLE with no loop active)
//     instr_valid/ready   loop instruction handshake (ready only in IDLE)
//     instr_start/indep/iters/jump  instruction fields
//     resp_valid          one-cycle pulse when an instruction retires
//     resp_jump           PC decrement for the retired instruction (0 = fall through)
//     resp_unroll         iterations covered by the next body batch
//     rd_idx/rd_addr/rd_daddr  registered APU read port (address and stride
//                         at the innermost active loop)
//     depth               number of active loops
//     err_ovf/udf/zero/cfg  sticky error flags; err_clr clears them
// -----------------------------------------------------------------------------
module loop_apu_sequencer #(
   parameter int unsigned LOOP_DEPTH        = 8,
   parameter int unsigned APU_CNT           = 8,
   parameter int unsigned ADDR_W            = 18,
   parameter int unsigned ITER_W            = 18,
   parameter int unsigned JUMP_W            = 8,
   parameter int unsigned SUPERSCALAR_WIDTH = 8
) (
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic                                   cfg_we,
   input  logic [$clog2(APU_CNT)-1:0]             cfg_idx,
   input  logic [ADDR_W-1:0]                      cfg_base,
   input  logic [LOOP_DEPTH*ADDR_W-1:0]           cfg_coef,
   input  logic                                   instr_valid,
   output logic                                   instr_ready,
   input  logic                                   instr_start,
   input  logic                                   instr_indep,
   input  logic [ITER_W-1:0]                      instr_iters,
   input  logic [JUMP_W-1:0]                      instr_jump,
   output logic                                   resp_valid,
   output logic [JUMP_W-1:0]                      resp_jump,
   output logic [$clog2(SUPERSCALAR_WIDTH+1)-1:0] resp_unroll,
   input  logic [$clog2(APU_CNT)-1:0]             rd_idx,
   output logic [ADDR_W-1:0]                      rd_addr,
   output logic [ADDR_W-1:0]                      rd_daddr,
   output logic [$clog2(LOOP_DEPTH+1)-1:0]        depth,
   output logic                                   err_ovf,
   output logic                                   err_udf,
   output logic                                   err_zero,
   output logic                                   err_cfg,
   input  logic                                   err_clr
);

   localparam int unsigned UW = $clog2(SUPERSCALAR_WIDTH + 1);
   localparam int unsigned DW = $clog2(LOOP_DEPTH + 1);
   localparam int unsigned LW = $clog2(LOOP_DEPTH);
   localparam int unsigned AW = $clog2(APU_CNT);

   typedef enum logic [1:0] {
      S_IDLE,
      S_EXEC,
      S_APU,
      S_RESP
   } state_e;

   state_e state_q, state_d;

   // loop stack
   logic [DW-1:0]     depth_q, depth_d;
   logic [ITER_W-1:0] val_q  [LOOP_DEPTH];
   logic [ITER_W-1:0] val_d  [LOOP_DEPTH];
   logic [ITER_W-1:0] tot_q  [LOOP_DEPTH];
   logic [ITER_W-1:0] tot_d  [LOOP_DEPTH];
   logic [UW-1:0]     step_q [LOOP_DEPTH];
   logic [UW-1:0]     step_d [LOOP_DEPTH];
   logic              ind_q  [LOOP_DEPTH];
   logic              ind_d  [LOOP_DEPTH];
   logic [JUMP_W-1:0] jmp_q  [LOOP_DEPTH];
   logic [JUMP_W-1:0] jmp_d  [LOOP_DEPTH];

   // APU registers and per-level strides
   logic [ADDR_W-1:0] apu_q  [APU_CNT];
   logic [ADDR_W-1:0] apu_d  [APU_CNT];
   logic [ADDR_W-1:0] coef_q [APU_CNT][LOOP_DEPTH];
   logic [ADDR_W-1:0] coef_d [APU_CNT][LOOP_DEPTH];

   // latched instruction
   logic              op_start_q, op_start_d;
   logic              op_indep_q, op_indep_d;
   logic [ITER_W-1:0] op_iters_q, op_iters_d;
   logic [JUMP_W-1:0] op_jump_q,  op_jump_d;

   // END decision carried from EXEC into APU, and pending response fields
   logic              exit_q, exit_d;
   logic [ITER_W-1:0] nv_q, nv_d;
   logic [JUMP_W-1:0] pjump_q, pjump_d;
   logic [UW-1:0]     punroll_q, punroll_d;

   logic              resp_valid_q, resp_valid_d;
   logic [JUMP_W-1:0] resp_jump_q, resp_jump_d;
   logic [UW-1:0]     resp_unroll_q, resp_unroll_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic [ADDR_W-1:0] rd_daddr_q, rd_daddr_d;

   logic err_ovf_q, err_ovf_d;
   logic err_udf_q, err_udf_d;
   logic err_zero_q, err_zero_d;
   logic err_cfg_q, err_cfg_d;

   logic [LW-1:0]     top;
   logic [LW-1:0]     top_next;
   logic [ITER_W:0]   nv_ext;
   logic [ITER_W-1:0] eff_iters;
   logic [ADDR_W-1:0] apu_mult;
   logic [UW-1:0]     new_step;

   // Iterations the next batch covers: whole remainder for independent
   // loops, capped at the superscalar width; dependent loops go one at a time.
   function automatic logic [UW-1:0] batch(input logic indep, input logic [ITER_W-1:0] remaining);
      if (!indep) begin
         return UW'(1);
      end
      if (remaining >= ITER_W'(SUPERSCALAR_WIDTH)) begin
         return UW'(SUPERSCALAR_WIDTH);
      end
      return UW'(remaining);
   endfunction

   assign top       = LW'(depth_q - DW'(1));
   assign top_next  = LW'(depth_d - DW'(1));
   assign nv_ext    = {1'b0, val_q[top]} + (ITER_W + 1)'(step_q[top]);
   assign eff_iters = (op_iters_q == '0) ? ITER_W'(1) : op_iters_q;
   // Exiting rewinds by the iterations already taken; continuing advances
   // by the batch just completed. Products are taken modulo 2^ADDR_W.
   assign apu_mult  = exit_q ? ADDR_W'(val_q[top]) : ADDR_W'(step_q[top]);

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: if (instr_valid) state_d = S_EXEC;
         S_EXEC: state_d = (op_start_q || depth_q == '0) ? S_RESP : S_APU;
         S_APU:  state_d = S_RESP;
         S_RESP: state_d = S_IDLE;
      endcase
   end

   // ----------------------------------------------------------- datapath
   always_comb begin
      depth_d       = depth_q;
      val_d         = val_q;
      tot_d         = tot_q;
      step_d        = step_q;
      ind_d         = ind_q;
      jmp_d         = jmp_q;
      apu_d         = apu_q;
      coef_d        = coef_q;
      op_start_d    = op_start_q;
      op_indep_d    = op_indep_q;
      op_iters_d    = op_iters_q;
      op_jump_d     = op_jump_q;
      exit_d        = exit_q;
      nv_d          = nv_q;
      pjump_d       = pjump_q;
      punroll_d     = punroll_q;
      resp_valid_d  = 1'b0;
      resp_jump_d   = resp_jump_q;
      resp_unroll_d = resp_unroll_q;
      new_step      = '0;
      // clear first so that an error raised this cycle wins over err_clr
      err_ovf_d     = err_ovf_q  & ~err_clr;
      err_udf_d     = err_udf_q  & ~err_clr;
      err_zero_d    = err_zero_q & ~err_clr;
      err_cfg_d     = err_cfg_q  & ~err_clr;

      if (cfg_we) begin
         if (state_q == S_IDLE && depth_q == '0) begin
            apu_d[cfg_idx] = cfg_base;
            for (int unsigned d = 0; d < LOOP_DEPTH; d++) begin
               coef_d[cfg_idx][LW'(d)] = cfg_coef[d*ADDR_W +: ADDR_W];
            end
         end else begin
            err_cfg_d = 1'b1;
         end
      end

      unique case (state_q)
         S_IDLE: begin
            if (instr_valid) begin
               op_start_d = instr_start;
               op_indep_d = instr_indep;
               op_iters_d = instr_iters;
               op_jump_d  = instr_jump;
            end
         end

         S_EXEC: begin
            if (op_start_q) begin
               if (op_iters_q == '0) begin
                  err_zero_d = 1'b1;
               end
               pjump_d = '0;
               if (depth_q == DW'(LOOP_DEPTH)) begin
                  err_ovf_d = 1'b1;
                  punroll_d = UW'(1);
               end else begin
                  new_step                = batch(op_indep_q, eff_iters);
                  val_d[LW'(depth_q)]     = '0;
                  tot_d[LW'(depth_q)]     = eff_iters;
                  step_d[LW'(depth_q)]    = new_step;
                  ind_d[LW'(depth_q)]     = op_indep_q;
                  jmp_d[LW'(depth_q)]     = op_jump_q;
                  depth_d                 = depth_q + DW'(1);
                  punroll_d               = new_step;
               end
            end else if (depth_q == '0) begin
               err_udf_d = 1'b1;
               pjump_d   = '0;
               punroll_d = UW'(1);
            end else begin
               exit_d = (nv_ext >= {1'b0, tot_q[top]});
               nv_d   = nv_ext[ITER_W-1:0];
            end
         end

         S_APU: begin
            for (int unsigned k = 0; k < APU_CNT; k++) begin
               if (exit_q) begin
                  apu_d[AW'(k)] = apu_q[AW'(k)] - coef_q[AW'(k)][top] * apu_mult;
               end else begin
                  apu_d[AW'(k)] = apu_q[AW'(k)] + coef_q[AW'(k)][top] * apu_mult;
               end
            end
            if (exit_q) begin
               val_d[top]  = '0;
               tot_d[top]  = '0;
               step_d[top] = '0;
               ind_d[top]  = 1'b0;
               jmp_d[top]  = '0;
               depth_d     = depth_q - DW'(1);
               pjump_d     = '0;
               punroll_d   = UW'(1);
            end else begin
               new_step    = batch(ind_q[top], tot_q[top] - nv_q);
               val_d[top]  = nv_q;
               step_d[top] = new_step;
               pjump_d     = jmp_q[top];
               punroll_d   = new_step;
            end
         end

         S_RESP: begin
            resp_valid_d  = 1'b1;
            resp_jump_d   = pjump_q;
            resp_unroll_d = punroll_q;
         end
      endcase

      // read port shows the state as it will be after this edge
      rd_addr_d  = apu_d[rd_idx];
      rd_daddr_d = (depth_d == '0) ? '0 : coef_d[rd_idx][top_next];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         depth_q       <= '0;
         val_q         <= '{default: '0};
         tot_q         <= '{default: '0};
         step_q        <= '{default: '0};
         ind_q         <= '{default: 1'b0};
         jmp_q         <= '{default: '0};
         apu_q         <= '{default: '0};
         coef_q        <= '{default: '{default: '0}};
         op_start_q    <= 1'b0;
         op_indep_q    <= 1'b0;
         op_iters_q    <= '0;
         op_jump_q     <= '0;
         exit_q        <= 1'b0;
         nv_q          <= '0;
         pjump_q       <= '0;
         punroll_q     <= '0;
         resp_valid_q  <= 1'b0;
         resp_jump_q   <= '0;
         resp_unroll_q <= '0;
         rd_addr_q     <= '0;
         rd_daddr_q    <= '0;
         err_ovf_q     <= 1'b0;
         err_udf_q     <= 1'b0;
         err_zero_q    <= 1'b0;
         err_cfg_q     <= 1'b0;
      end else begin
         depth_q       <= depth_d;
         val_q         <= val_d;
         tot_q         <= tot_d;
         step_q        <= step_d;
         ind_q         <= ind_d;
         jmp_q         <= jmp_d;
         apu_q         <= apu_d;
         coef_q        <= coef_d;
         op_start_q    <= op_start_d;
         op_indep_q    <= op_indep_d;
         op_iters_q    <= op_iters_d;
         op_jump_q     <= op_jump_d;
         exit_q        <= exit_d;
         nv_q          <= nv_d;
         pjump_q       <= pjump_d;
         punroll_q     <= punroll_d;
         resp_valid_q  <= resp_valid_d;
         resp_jump_q   <= resp_jump_d;
         resp_unroll_q <= resp_unroll_d;
         rd_addr_q     <= rd_addr_d;
         rd_daddr_q    <= rd_daddr_d;
         err_ovf_q     <= err_ovf_d;
         err_udf_q     <= err_udf_d;
         err_zero_q    <= err_zero_d;
         err_cfg_q     <= err_cfg_d;
      end
   end

   assign instr_ready = (state_q == S_IDLE);
   assign resp_valid  = resp_valid_q;
   assign resp_jump   = resp_jump_q;
   assign resp_unroll = resp_unroll_q;
   assign rd_addr     = rd_addr_q;
   assign rd_daddr    = rd_daddr_q;
   assign depth       = depth_q;
   assign err_ovf     = err_ovf_q;
   assign err_udf     = err_udf_q;
   assign err_zero    = err_zero_q;
   assign err_cfg     = err_cfg_q;

endmodule

// File: tb/tb_loop_apu_sequencer.sv
module tb_loop_apu_sequencer;

   logic         clk;
   logic         reset;
   logic         cfg_we;
   logic [2:0]   cfg_idx;
   logic [17:0]  cfg_base;
   logic [143:0] cfg_coef;
   logic         instr_valid;
   logic         instr_ready;
   logic         instr_start;
   logic         instr_indep;
   logic [17:0]  instr_iters;
   logic [7:0]   instr_jump;
   logic         resp_valid;
   logic [7:0]   resp_jump;
   logic [3:0]   resp_unroll;
   logic [2:0]   rd_idx;
   logic [17:0]  rd_addr;
   logic [17:0]  rd_daddr;
   logic [3:0]   depth;
   logic         err_ovf, err_udf, err_zero, err_cfg, err_clr;

   int checks = 0;
   int errors = 0;
   int m_depth = 0;

   typedef struct {
      int jump;
      int unroll;
      int lat;
      int addr;
      int daddr;
      int dep;
   } exp_t;

   exp_t sb[$];

   loop_apu_sequencer #(
      .LOOP_DEPTH(8), .APU_CNT(8), .ADDR_W(18), .ITER_W(18), .JUMP_W(8), .SUPERSCALAR_WIDTH(8)
   ) dut (
      .clk(clk), .reset(reset),
      .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_base(cfg_base), .cfg_coef(cfg_coef),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_start(instr_start),
      .instr_indep(instr_indep), .instr_iters(instr_iters), .instr_jump(instr_jump),
      .resp_valid(resp_valid), .resp_jump(resp_jump), .resp_unroll(resp_unroll),
      .rd_idx(rd_idx), .rd_addr(rd_addr), .rd_daddr(rd_daddr), .depth(depth),
      .err_ovf(err_ovf), .err_udf(err_udf), .err_zero(err_zero), .err_cfg(err_cfg),
      .err_clr(err_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   // Drive one instruction, queue its expected response, then wait (bounded)
   // for the response pulse and compare it against the queued expectation.
   task automatic issue(input string name, input logic st, input logic ind, input int it,
                        input int jp, input int ej, input int eu, input int ea,
                        input int ed, input int edp);
      exp_t e;
      exp_t g;
      int   lat;
      e.jump   = ej;
      e.unroll = eu;
      e.lat    = (st || m_depth == 0) ? 2 : 3;
      e.addr   = ea;
      e.daddr  = ed;
      e.dep    = edp;
      sb.push_back(e);
      m_depth  = edp;
      @(negedge clk);
      checks++;
      if (instr_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s ready: got %b want 1", name, instr_ready);
      end
      instr_valid = 1'b1;
      instr_start = st;
      instr_indep = ind;
      instr_iters = 18'(it);
      instr_jump  = 8'(jp);
      @(posedge clk);
      #1;
      instr_valid = 1'b0;
      cfg_we      = 1'b0;
      checks++;
      if (resp_valid !== 1'b0) begin
         errors++;
         $display("FAIL %s pulse_width: got %b want 0", name, resp_valid);
      end
      lat = 0;
      do begin
         @(posedge clk);
         #1;
         lat++;
      end while (resp_valid !== 1'b1 && lat < 10);
      checks++;
      if (resp_valid !== 1'b1) begin
         errors++;
         $display("FAIL %s resp_timeout: got no resp want resp", name);
         void'(sb.pop_front());
      end else begin
         g = sb.pop_front();
         checks++;
         if (lat != g.lat) begin
            errors++;
            $display("FAIL %s latency: got %0d want %0d", name, lat, g.lat);
         end
         checks++;
         if (resp_jump !== 8'(g.jump)) begin
            errors++;
            $display("FAIL %s resp_jump: got %0d want %0d", name, resp_jump, g.jump);
         end
         checks++;
         if (resp_unroll !== 4'(g.unroll)) begin
            errors++;
            $display("FAIL %s resp_unroll: got %0d want %0d", name, resp_unroll, g.unroll);
         end
         checks++;
         if (rd_addr !== 18'(g.addr)) begin
            errors++;
            $display("FAIL %s rd_addr: got %0d want %0d", name, rd_addr, g.addr);
         end
         checks++;
         if (rd_daddr !== 18'(g.daddr)) begin
            errors++;
            $display("FAIL %s rd_daddr: got %0d want %0d", name, rd_daddr, g.daddr);
         end
         checks++;
         if (depth !== 4'(g.dep)) begin
            errors++;
            $display("FAIL %s depth: got %0d want %0d", name, depth, g.dep);
         end
      end
   endtask

   task automatic do_cfg(input int idx, input int base, input logic [143:0] coef);
      @(negedge clk);
      cfg_we   = 1'b1;
      cfg_idx  = 3'(idx);
      cfg_base = 18'(base);
      cfg_coef = coef;
      @(posedge clk);
      #1;
      cfg_we = 1'b0;
   endtask

   task automatic pulse_clr();
      @(negedge clk);
      err_clr = 1'b1;
      @(posedge clk);
      #1;
      err_clr = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (instr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", instr_ready); end
      checks++;
      if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
      checks++;
      if (resp_jump !== 8'd0 || resp_unroll !== 4'd0) begin
         errors++;
         $display("FAIL reset_resp_fields: got %0d/%0d want 0/0", resp_jump, resp_unroll);
      end
      checks++;
      if (rd_addr !== 18'd0 || rd_daddr !== 18'd0) begin
         errors++;
         $display("FAIL reset_rd: got %0d/%0d want 0/0", rd_addr, rd_daddr);
      end
      checks++;
      if (depth !== 4'd0) begin errors++; $display("FAIL reset_depth: got %0d want 0", depth); end
      checks++;
      if ({err_ovf, err_udf, err_zero, err_cfg} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_errs: got %b want 0000", {err_ovf, err_udf, err_zero, err_cfg});
      end
   endtask

   task automatic test_single_loop();
      logic [143:0] cv;
      cv = '0;
      cv[17:0] = 18'd4;
      do_cfg(0, 100, cv);
      checks++;
      if (rd_addr !== 18'd100) begin errors++; $display("FAIL cfg_rd_addr: got %0d want 100", rd_addr); end
      issue("single_start", 1'b1, 1'b0, 3, 5, 0, 1, 100, 4, 1);
      issue("single_end1",  1'b0, 1'b0, 0, 0, 5, 1, 104, 4, 1);
      issue("single_end2",  1'b0, 1'b0, 0, 0, 5, 1, 108, 4, 1);
      issue("single_end3",  1'b0, 1'b0, 0, 0, 0, 1, 100, 0, 0);
   endtask

   task automatic test_unroll();
      issue("unroll_start", 1'b1, 1'b1, 20, 7, 0, 8, 100, 4, 1);
      issue("unroll_end1",  1'b0, 1'b0, 0, 0, 7, 8, 132, 4, 1);
      issue("unroll_end2",  1'b0, 1'b0, 0, 0, 7, 4, 164, 4, 1);
      issue("unroll_end3",  1'b0, 1'b0, 0, 0, 0, 1, 100, 0, 0);
   endtask

   task automatic test_nested();
      logic [143:0] cv;
      cv = '0;
      cv[17:0]  = 18'd64;
      cv[35:18] = 18'd4;
      do_cfg(0, 0, cv);
      issue("nest_outer",    1'b1, 1'b0, 2, 10, 0,  1, 0,  64, 1);
      issue("nest_inner",    1'b1, 1'b0, 2, 3,  0,  1, 0,  4,  2);
      issue("nest_in_end1",  1'b0, 1'b0, 0, 0,  3,  1, 4,  4,  2);
      issue("nest_in_exit",  1'b0, 1'b0, 0, 0,  0,  1, 0,  64, 1);
      issue("nest_out_end1", 1'b0, 1'b0, 0, 0,  10, 1, 64, 64, 1);
      issue("nest_inner2",   1'b1, 1'b0, 2, 3,  0,  1, 64, 4,  2);
      issue("nest_in2_end1", 1'b0, 1'b0, 0, 0,  3,  1, 68, 4,  2);
      issue("nest_in2_exit", 1'b0, 1'b0, 0, 0,  0,  1, 64, 64, 1);
      issue("nest_out_exit", 1'b0, 1'b0, 0, 0,  0,  1, 0,  0,  0);
   endtask

   task automatic test_overflow();
      logic [143:0] cv;
      cv = '0;
      for (int d = 0; d < 8; d++) cv[d*18 +: 18] = 18'(d + 1);
      do_cfg(0, 50, cv);
      for (int n = 1; n <= 8; n++) issue("ovf_push", 1'b1, 1'b0, 1, 0, 0, 1, 50, n, n);
      issue("ovf_9th", 1'b1, 1'b0, 1, 0, 0, 1, 50, 8, 8);
      checks++;
      if (err_ovf !== 1'b1) begin errors++; $display("FAIL err_ovf: got %b want 1", err_ovf); end
      for (int n = 7; n >= 0; n--) issue("ovf_pop", 1'b0, 1'b0, 0, 0, 0, 1, 50, n, n);
      checks++;
      if (err_udf !== 1'b0) begin errors++; $display("FAIL err_udf_early: got %b want 0", err_udf); end
      issue("udf_end", 1'b0, 1'b0, 0, 0, 0, 1, 50, 0, 0);
      checks++;
      if (err_udf !== 1'b1) begin errors++; $display("FAIL err_udf: got %b want 1", err_udf); end
   endtask

   task automatic test_cfg_err();
      pulse_clr();
      checks++;
      if ({err_ovf, err_udf, err_zero, err_cfg} !== 4'b0000) begin
         errors++;
         $display("FAIL err_clr_all: got %b want 0000", {err_ovf, err_udf, err_zero, err_cfg});
      end
      issue("cfgerr_start", 1'b1, 1'b0, 2, 9, 0, 1, 50, 1, 1);
      do_cfg(0, 999, '0);
      checks++;
      if (err_cfg !== 1'b1) begin errors++; $display("FAIL err_cfg: got %b want 1", err_cfg); end
      checks++;
      if (rd_addr !== 18'd50 || rd_daddr !== 18'd1) begin
         errors++;
         $display("FAIL cfg_ignored: got %0d/%0d want 50/1", rd_addr, rd_daddr);
      end
      @(negedge clk);
      cfg_we  = 1'b1;
      err_clr = 1'b1;
      @(posedge clk);
      #1;
      cfg_we  = 1'b0;
      err_clr = 1'b0;
      checks++;
      if (err_cfg !== 1'b1) begin errors++; $display("FAIL err_new_wins: got %b want 1", err_cfg); end
      pulse_clr();
      checks++;
      if (err_cfg !== 1'b0) begin errors++; $display("FAIL err_cfg_clr: got %b want 0", err_cfg); end
      issue("cfgerr_end1", 1'b0, 1'b0, 0, 0, 9, 1, 51, 1, 1);
      issue("cfgerr_exit", 1'b0, 1'b0, 0, 0, 0, 1, 50, 0, 0);
      issue("zero_start",  1'b1, 1'b1, 0, 4, 0, 1, 50, 1, 1);
      checks++;
      if (err_zero !== 1'b1) begin errors++; $display("FAIL err_zero: got %b want 1", err_zero); end
      issue("zero_exit",   1'b0, 1'b0, 0, 0, 0, 1, 50, 0, 0);
   endtask

   task automatic test_cfg_and_accept();
      logic [143:0] cv;
      cv = '0;
      cv[17:0] = 18'd2;
      cfg_we   = 1'b1;
      cfg_idx  = 3'd0;
      cfg_base = 18'd200;
      cfg_coef = cv;
      issue("cfgacc_start", 1'b1, 1'b0, 2, 6, 0, 1, 200, 2, 1);
      issue("cfgacc_end1",  1'b0, 1'b0, 0, 0, 6, 1, 202, 2, 1);
      issue("cfgacc_exit",  1'b0, 1'b0, 0, 0, 0, 1, 200, 0, 0);
   endtask

   task automatic test_reset_mid();
      issue("rmid_start", 1'b1, 1'b0, 3, 1, 0, 1, 200, 2, 1);
      @(negedge clk);
      instr_valid = 1'b1;
      instr_start = 1'b0;
      @(posedge clk);
      #1;
      instr_valid = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      checks++;
      if (resp_valid !== 1'b0 || resp_jump !== 8'd0 || resp_unroll !== 4'd0) begin
         errors++;
         $display("FAIL rmid_resp: got %b/%0d/%0d want 0/0/0", resp_valid, resp_jump, resp_unroll);
      end
      checks++;
      if (rd_addr !== 18'd0 || rd_daddr !== 18'd0 || depth !== 4'd0) begin
         errors++;
         $display("FAIL rmid_state: got %0d/%0d/%0d want 0/0/0", rd_addr, rd_daddr, depth);
      end
      checks++;
      if ({err_ovf, err_udf, err_zero, err_cfg} !== 4'b0000) begin
         errors++;
         $display("FAIL rmid_errs: got %b want 0000", {err_ovf, err_udf, err_zero, err_cfg});
      end
      m_depth = 0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         checks++;
         if (resp_valid !== 1'b0) begin errors++; $display("FAIL rmid_no_resp: got %b want 0", resp_valid); end
      end
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         checks++;
         if (resp_valid !== 1'b0) begin errors++; $display("FAIL rmid_post_resp: got %b want 0", resp_valid); end
      end
      checks++;
      if (instr_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready: got %b want 1", instr_ready); end
      checks++;
      if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover: got %0d want 0", sb.size()); end
   endtask

   initial begin
      reset       = 1'b0;
      cfg_we      = 1'b0;
      cfg_idx     = '0;
      cfg_base    = '0;
      cfg_coef    = '0;
      instr_valid = 1'b0;
      instr_start = 1'b0;
      instr_indep = 1'b0;
      instr_iters = '0;
      instr_jump  = '0;
      rd_idx      = '0;
      err_clr     = 1'b0;
      test_reset();
      test_single_loop();
      test_unroll();
      test_nested();
      test_overflow();
      test_cfg_err();
      test_cfg_and_accept();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
